// File: rtl/mem2_load_align_fwd.sv
// MEM2 load-data aligner: merges younger buffered stores over the D-cache word,
// then extracts/extends per load type into a 1-deep registered output stage.
module mem2_load_align_fwd #(
    parameter  int SB_DEPTH = 4,
    localparam int CNT_W    = $clog2(SB_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_ldtype,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_cache_rdata,
    input  logic [31:0]      in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_fwd_hit,
    output logic             out_bad_type,
    input  logic             sb_push_valid,
    output logic             sb_push_ready,
    input  logic [31:0]      sb_push_addr,
    input  logic [31:0]      sb_push_data,
    input  logic [3:0]       sb_push_strb,
    input  logic             sb_pop,
    output logic [CNT_W-1:0] sb_count,
    output logic             sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    logic [29:0]      sb_addr_q [SB_DEPTH];
    logic [31:0]      sb_data_q [SB_DEPTH];
    logic [3:0]       sb_strb_q [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] sb_count_q;

    logic             out_valid_q, out_fwd_hit_q, out_bad_type_q;
    logic [31:0]      out_data_q;

    logic             push_fire, pop_fire, accept;
    logic [PTR_W-1:0] slot;
    logic [31:0]      merged;
    logic [3:0]       fwd_lane;
    logic [31:0]      shifted, data_d;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             bad_d;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^sb_push_addr[1:0];

    assign sb_push_ready = (sb_count_q != CNT_W'(SB_DEPTH));
    assign sb_empty      = (sb_count_q == '0);
    assign sb_count      = sb_count_q;
    assign push_fire     = sb_push_valid & sb_push_ready;
    assign pop_fire      = sb_pop & ~sb_empty;

    assign in_ready      = ~out_valid_q | out_ready;
    assign accept        = in_valid & in_ready;

    // Walk oldest to youngest so later matches overwrite earlier ones per lane.
    always_comb begin
        merged   = in_cache_rdata;
        fwd_lane = '0;
        slot     = rd_ptr_q;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < sb_count_q) && (sb_addr_q[slot] == in_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb_strb_q[slot][b]) begin
                        merged[8*b +: 8] = sb_data_q[slot][8*b +: 8];
                        fwd_lane[b]      = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        shifted  = merged >> {in_addr[1:0], 3'b000};
        sel_byte = shifted[7:0];
        sel_half = in_addr[1] ? merged[31:16] : merged[15:0];
        data_d   = '0;
        bad_d    = 1'b0;
        case (in_ldtype)
            LD_LB:  data_d = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU: data_d = {24'h0, sel_byte};
            LD_LH:  data_d = {{16{sel_half[15]}}, sel_half};
            LD_LHU: data_d = {16'h0, sel_half};
            LD_LW:  data_d = merged;
            LD_LWL: begin
                case (in_addr[1:0])
                    2'd0:    data_d = {merged[7:0],  in_rt[23:0]};
                    2'd1:    data_d = {merged[15:0], in_rt[15:0]};
                    2'd2:    data_d = {merged[23:0], in_rt[7:0]};
                    default: data_d = merged;
                endcase
            end
            LD_LWR: begin
                case (in_addr[1:0])
                    2'd0:    data_d = merged;
                    2'd1:    data_d = {in_rt[31:24], merged[31:8]};
                    2'd2:    data_d = {in_rt[31:16], merged[31:16]};
                    default: data_d = {in_rt[31:8],  merged[31:24]};
                endcase
            end
            default: bad_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sb_count_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
                sb_strb_q[i] <= '0;
            end
        end else begin
            if (push_fire) begin
                sb_addr_q[wr_ptr_q] <= sb_push_addr[31:2];
                sb_data_q[wr_ptr_q] <= sb_push_data;
                sb_strb_q[wr_ptr_q] <= sb_push_strb;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            sb_count_q <= sb_count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

    // Flush only kills the valid bit; the payload is don't-care while invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_fwd_hit_q  <= 1'b0;
            out_bad_type_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q    <= 1'b1;
            out_data_q     <= data_d;
            out_fwd_hit_q  <= |fwd_lane;
            out_bad_type_q <= bad_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_fwd_hit  = out_fwd_hit_q;
    assign out_bad_type = out_bad_type_q;

endmodule
